piso_transmitter: RTL and testbench

- Parallel-in, serial-out transmitter: the read-out end for an N-bit word held in a loadable register.
- Accepts a word on a start strobe and emits it LSB-first, one bit per clock, with a valid qualifier.
- Pulses done after the last bit.
- Sits between the datapath's result register and a serial test/observation port.

---
 rtl/piso_pkg.sv | 22 ++
 rtl/piso_transmitter_bit_counter.sv | 37 +++
 rtl/piso_transmitter.sv | 122 ++++++++++++
 tb/tb_piso_transmitter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared definitions for the parallel-in/serial-out transmitter.
//   state_e : FSM state encoding (IDLE=0, SHIFT=1, DONE=2, PARITY=3)
//   clog2   : constant width helper used to size the bit counter
// PARITY is only reachable when PISO_PARITY_EN is defined.
package piso_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_DONE   = 2'd2,
        S_PARITY = 2'd3
    } state_e;

    // Smallest r such that 2**r >= v.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/piso_transmitter_bit_counter.sv
// bit_counter: clearable, enabled up-counter with a terminal-count flag.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   clr      : synchronous clear to 0 (has priority over en)
//   en       : increment by one on the rising edge
//   cnt      : current count
//   term     : high while cnt == TERM
module bit_counter
    import piso_pkg::*;
#(
    parameter int            CW   = 5,
    parameter logic [CW-1:0] TERM = '1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          term
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign term = (cnt_q == TERM);

endmodule

// File: rtl/piso_transmitter.sv
// piso_transmitter: loads an N-bit word on start (IDLE only) and emits it
// LSB-first, one bit per clock, qualified by ser_valid; done pulses for one
// cycle after the last bit.
//   clk, rst  : clock, asynchronous active-high reset
//   din       : parallel word, sampled when start is accepted
//   start     : transmit request, honoured only in IDLE (not queued)
//   busy      : high in every non-IDLE state
//   ser_out   : serial bit, 0 when ser_valid is low
//   ser_valid : ser_out carries a payload bit
//   done      : one-cycle pulse after the final bit
// Build option PISO_PARITY_EN: appends an even-parity bit (XOR of the word
// captured at acceptance) as one extra valid cycle before DONE.
module piso_transmitter
    import piso_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    input  logic         start,
    output logic         busy,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         done
);

    localparam int            CW   = clog2(N + 1);
    localparam logic [CW-1:0] TERM = CW'(N - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] cnt;
    logic          cnt_term;
    logic          cnt_clr;
    logic          cnt_en;
`ifdef PISO_PARITY_EN
    logic          par_q, par_d;
`endif

    // The counter holds at N-1 once reached; only a new acceptance clears it.
    bit_counter #(.CW(CW), .TERM(TERM)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .cnt  (cnt),
        .term (cnt_term)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        busy      = 1'b0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        done      = 1'b0;
`ifdef PISO_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d = din;
                    cnt_clr = 1'b1;
                    state_d = S_SHIFT;
`ifdef PISO_PARITY_EN
                    par_d   = ^din;
`endif
                end
            end
            S_SHIFT: begin
                busy      = 1'b1;
                ser_valid = 1'b1;
                ser_out   = shreg_q[0];
                shreg_d   = shreg_q >> 1;
                cnt_en    = (cnt < TERM);
                if (cnt_term) begin
`ifdef PISO_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            S_PARITY: begin
                busy      = 1'b1;
                ser_valid = 1'b1;
                ser_out   = par_q;
                state_d   = S_DONE;
            end
`endif
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_q <= 1'b0;
        else     par_q <= par_d;
    end
`endif

endmodule

// File: tb/tb_piso_transmitter.sv
// Testbench for piso_transmitter: directed and random words checked
// against a per-word reference stream (data bits LSB-first, optional parity).
module tb_piso_transmitter;

    localparam int N = 16;
`ifdef PISO_PARITY_EN
    localparam int L = N + 1;
`else
    localparam int L = N;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] din = '0;
    logic         start = 1'b0;
    logic         busy, ser_out, ser_valid, done;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int prev_acc = 0;

    piso_transmitter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .start     (start),
        .busy      (busy),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected serial bit k (0-based) of a word: data LSB-first, then parity.
    function automatic logic exp_bit(input logic [N-1:0] w, input int k);
        if (k < N) return logic'((w >> k) & 1);
        return ^w;
    endfunction

    // Called right after a negedge with the DUT idle. Drives start for one
    // edge; optional disturbances: clear din after acceptance, poke start
    // with 16'hFFFF mid-word, or keep start high with next_w for back-to-back.
    task automatic xfer(input logic [N-1:0] w, input bit clr_din, input bit poke,
                        input bit hold, input logic [N-1:0] next_w);
        din   = w;
        start = 1'b1;
        chk("idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        prev_acc = acc_cyc;
        acc_cyc  = cyc;
        if (hold) din = next_w;
        else      start = 1'b0;
        for (int k = 1; k <= L + 1; k++) begin
            chk($sformatf("busy_k%0d", k), 32'(busy), 32'd1);
            chk($sformatf("valid_k%0d", k), 32'(ser_valid), 32'(k <= L));
            chk($sformatf("bit_k%0d", k), 32'(ser_out), (k <= L) ? 32'(exp_bit(w, k - 1)) : 32'd0);
            chk($sformatf("done_k%0d", k), 32'(done), 32'(k == L + 1));
            if (clr_din && k == 1) din = '0;
            if (poke && k == 5) begin start = 1'b1; din = 16'hFFFF; end
            if (poke && k == 6) start = 1'b0;
            @(negedge clk);
        end
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_valid", 32'(ser_valid), 32'd0);
        chk("post_done", 32'(done), 32'd0);
    endtask

    initial begin
        logic any_done, any_busy;
        logic [N-1:0] w;

        // Reset state
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(ser_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed: A5C3, start re-pulsed mid-word, din changed after accept
        xfer(16'hA5C3, 1'b0, 1'b0, 1'b0, '0);
        xfer(16'hA5C3, 1'b0, 1'b1, 1'b0, '0);
        xfer(16'h00FF, 1'b1, 1'b0, 1'b0, '0);

        // Back-to-back with start held high
        xfer(16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000);
        xfer(16'h8000, 1'b0, 1'b0, 1'b0, '0);
        chk("b2b_spacing", 32'(acc_cyc - prev_acc), 32'(L + 2));

        // Parity-relevant words (plain words when parity is not built in)
        xfer(16'h0007, 1'b0, 1'b0, 1'b0, '0);
        xfer(16'h0003, 1'b0, 1'b0, 1'b0, '0);

        // Asynchronous reset mid-SHIFT while bit 5 is on the line
        din   = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_bit5", 32'(ser_out), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(ser_valid), 32'd0);
        chk("arst_out", 32'(ser_out), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        any_done = 1'b0;
        any_busy = 1'b0;
        repeat (L + 4) begin
            @(negedge clk);
            any_done |= done;
            any_busy |= busy;
        end
        chk("arst_no_done", 32'(any_done), 32'd0);
        chk("arst_no_busy", 32'(any_busy), 32'd0);

        // Random words with random disturbances
        for (int i = 0; i < 20; i++) begin
            w = N'($urandom);
            xfer(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
